fractal_sync_mp_rf: RTL

// - Multi-port, multi-bank sync register file; next generation of the fractal sync RF.
// - Serves N_PORTS requesters (local sync nodes / cores) with byte-masked READ/WRITE.
// - Adds an atomic SYNC op: arrival counter increment with threshold compare and

---
 rtl/fractal_sync_rf_pkg.sv | 26 ++
 rtl/fractal_sync_rf_bank.sv | 108 ++++++++++
 rtl/fractal_sync_mp_rf.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fractal_sync_rf_pkg.sv
// Shared types and address helpers for the fractal sync multi-port register file.
package fractal_sync_rf_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        RF_READ  = 2'd0,
        RF_WRITE = 2'd1,
        RF_SYNC  = 2'd2,
        RF_RSVD  = 2'd3
    } rf_op_e;

    // Index width that stays at least one bit for single-entry dimensions.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned bank_of(input int unsigned addr, input int unsigned n_banks);
        return addr % n_banks;
    endfunction

    function automatic int unsigned row_of(input int unsigned addr, input int unsigned n_banks);
        return addr / n_banks;
    endfunction

endpackage

// File: rtl/fractal_sync_rf_bank.sv
// One word-interleaved bank: storage, round-robin port arbiter, op execution and
// the registered response tagged with the winning port.
module fractal_sync_rf_bank
    import fractal_sync_rf_pkg::*;
#(
    parameter  int unsigned N_WORDS = 16,
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned BYTE_W  = 8,
    parameter  int unsigned N_PORTS = 4,
    localparam int unsigned ROW_W   = idx_w(N_WORDS),
    localparam int unsigned PORT_W  = idx_w(N_PORTS),
    localparam int unsigned NB      = DATA_W / BYTE_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_PORTS-1:0] req_i,
    input  logic [ROW_W-1:0]   row_i   [N_PORTS],
    input  rf_op_e             op_i    [N_PORTS],
    input  logic [DATA_W-1:0]  wdata_i [N_PORTS],
    input  logic [NB-1:0]      be_i    [N_PORTS],
    output logic [N_PORTS-1:0] gnt_c,
    output logic               rvalid_o,
    output logic [PORT_W-1:0]  rport_o,
    output logic [DATA_W-1:0]  rdata_o,
    output logic               done_o
);

    logic [DATA_W-1:0] mem_q [N_WORDS];
    logic [PORT_W-1:0] ptr_q;
    logic [PORT_W-1:0] sel;
    logic              found;
    logic              row_ok;
    logic [ROW_W-1:0]  row_sel;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] inc;
    logic [DATA_W-1:0] nxt;
    logic [DATA_W-1:0] rdata_c;
    logic              done_c;

    // Round-robin search starting at the pointer.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        gnt_c = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            int unsigned idx;
            idx = 32'(ptr_q) + i;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            if (!found && req_i[PORT_W'(idx)]) begin
                found = 1'b1;
                sel   = PORT_W'(idx);
            end
        end
        if (found) gnt_c[sel] = 1'b1;
    end

    always_comb begin
        row_sel = row_i[sel];
        row_ok  = 32'(row_sel) < N_WORDS;
        word    = row_ok ? mem_q[row_sel] : '0;
        inc     = word + DATA_W'(1);
        nxt     = word;
        rdata_c = word;
        done_c  = 1'b0;
        case (op_i[sel])
            RF_WRITE: begin
                rdata_c = '0;
                for (int unsigned b = 0; b < NB; b++) begin
                    if (be_i[sel][b]) nxt[b*BYTE_W +: BYTE_W] = wdata_i[sel][b*BYTE_W +: BYTE_W];
                end
            end
            RF_SYNC: begin
                if (inc >= wdata_i[sel]) begin
                    nxt    = '0;
                    done_c = 1'b1;
                end else begin
                    nxt = inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned w = 0; w < N_WORDS; w++) mem_q[w] <= '0;
            ptr_q    <= '0;
            rvalid_o <= 1'b0;
            rport_o  <= '0;
            rdata_o  <= '0;
            done_o   <= 1'b0;
        end else begin
            rvalid_o <= found;
            if (found) begin
                if (row_ok) mem_q[row_sel] <= nxt;
                ptr_q   <= (32'(sel) == N_PORTS - 1) ? '0 : sel + PORT_W'(1);
                rport_o <= sel;
                rdata_o <= rdata_c;
                done_o  <= done_c;
            end
        end
    end

`ifndef SYNTHESIS
    a_one_gnt: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_c));
`endif

endmodule

// File: rtl/fractal_sync_mp_rf.sv
// Multi-port, multi-bank sync register file with byte-masked READ/WRITE and an
// atomic SYNC arrival counter for barrier bookkeeping.
module fractal_sync_mp_rf
    import fractal_sync_rf_pkg::*;
#(
    parameter  int unsigned N_BANKS = 4,
    parameter  int unsigned N_WORDS = 16,
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned BYTE_W  = 8,
    parameter  int unsigned N_PORTS = 4,
    localparam int unsigned ADDR_W  = idx_w(N_BANKS * N_WORDS),
    localparam int unsigned NB      = DATA_W / BYTE_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_PORTS-1:0]        req_i,
    output logic [N_PORTS-1:0]        gnt_o,
    input  logic [N_PORTS*ADDR_W-1:0] addr_i,
    input  logic [N_PORTS*OP_W-1:0]   op_i,
    input  logic [N_PORTS*DATA_W-1:0] wdata_i,
    input  logic [N_PORTS*NB-1:0]     be_i,
    output logic [N_PORTS-1:0]        rvalid_o,
    output logic [N_PORTS*DATA_W-1:0] rdata_o,
    output logic [N_PORTS-1:0]        done_o,
    output logic [N_PORTS-1:0]        err_o
);

    localparam int unsigned ROW_W  = idx_w(N_WORDS);
    localparam int unsigned PORT_W = idx_w(N_PORTS);
    localparam int unsigned BANK_W = idx_w(N_BANKS);
    localparam int unsigned DEPTH  = N_BANKS * N_WORDS;

    logic [N_PORTS-1:0] bad;
    logic [N_PORTS-1:0] err_q;
    logic [ROW_W-1:0]   row    [N_PORTS];
    rf_op_e             op     [N_PORTS];
    logic [DATA_W-1:0]  wdata  [N_PORTS];
    logic [NB-1:0]      be     [N_PORTS];
    logic [N_PORTS-1:0] breq   [N_BANKS];
    logic [N_PORTS-1:0] bgnt   [N_BANKS];
    logic               brvalid[N_BANKS];
    logic [PORT_W-1:0]  brport [N_BANKS];
    logic [DATA_W-1:0]  brdata [N_BANKS];
    logic               bdone  [N_BANKS];

    // Decode: bad requests bypass arbitration, the rest go to their bank.
    always_comb begin
        bad = '0;
        for (int unsigned b = 0; b < N_BANKS; b++) breq[b] = '0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            int unsigned a;
            a        = 32'(addr_i[p*ADDR_W +: ADDR_W]);
            op[p]    = rf_op_e'(op_i[p*OP_W +: OP_W]);
            row[p]   = ROW_W'(row_of(a, N_BANKS));
            wdata[p] = wdata_i[p*DATA_W +: DATA_W];
            be[p]    = be_i[p*NB +: NB];
            if (req_i[p]) begin
                if (a >= DEPTH || op[p] == RF_RSVD) bad[p] = 1'b1;
                else breq[BANK_W'(bank_of(a, N_BANKS))][p] = 1'b1;
            end
        end
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        fractal_sync_rf_bank #(
            .N_WORDS(N_WORDS),
            .DATA_W (DATA_W),
            .BYTE_W (BYTE_W),
            .N_PORTS(N_PORTS)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .req_i   (breq[b]),
            .row_i   (row),
            .op_i    (op),
            .wdata_i (wdata),
            .be_i    (be),
            .gnt_c   (bgnt[b]),
            .rvalid_o(brvalid[b]),
            .rport_o (brport[b]),
            .rdata_o (brdata[b]),
            .done_o  (bdone[b])
        );
    end

    always_comb begin
        gnt_o = bad;
        for (int unsigned b = 0; b < N_BANKS; b++) gnt_o = gnt_o | bgnt[b];
        if (rst_i) gnt_o = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= '0;
        else       err_q <= bad;
    end

    // Steer each bank's registered response back to the port it served.
    always_comb begin
        rvalid_o = err_q;
        err_o    = err_q;
        done_o   = '0;
        rdata_o  = '0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            for (int unsigned b = 0; b < N_BANKS; b++) begin
                if (brvalid[b] && brport[b] == PORT_W'(p)) begin
                    rvalid_o[p]                  = 1'b1;
                    done_o[p]                    = bdone[b];
                    rdata_o[p*DATA_W +: DATA_W]  = brdata[b];
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_gnt_req: assert property (@(posedge clk_i) disable iff (rst_i) (gnt_o & ~req_i) == '0);
    for (genvar p = 0; p < N_PORTS; p++) begin : g_chk
        a_op_stable: assert property (@(posedge clk_i) disable iff (rst_i)
            (req_i[p] && !gnt_o[p]) |=> $stable(op_i[p*OP_W +: OP_W]));
    end
`endif

endmodule
